grad_mag_bin: RTL and testbench
===============================

Name: grad_mag_bin

Overview:
- Streaming HOG gradient stage: consumes a raster pixel stream and computes, per interior pixel, the central-difference gradient.
- Outputs squared magnitude gx²+gy² (18 bit, feeds the `sqrt` stage directly) and an unsigned 9-bin orientation index (feeds the cell histogram stage).
- Two line buffers plus a 3-column window; fixed-latency pipeline with no backpressure.

Parameters:
- IMG_W, 64, pixels per row (≥3)
- IMG_H, 64, rows per frame (≥3)
- PIX_W, 8, pixel width, unsigned

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  pixel present this cycle
- in_sof  in  1  qualifies in_valid; pixel is (row 0, col 0) of a new frame
- in_pixel  in  PIX_W  unsigned pixel
- out_valid  out  1  result present
- out_mag_sq  out  2*PIX_W+2  gx²+gy², unsigned
- out_bin  out  4  orientation bin 0..8

Behaviour:
- Reset, sampled at posedge while rst_n=0:
  - out_valid=0, out_mag_sq=0, out_bin=0.
  - Row/col counters go to 0 and pipeline valids clear.
  - Line buffer contents are don't-care.
  - Reset mid-frame discards the partial frame; the next accepted pixel is treated as (0,0).
- Pixel acceptance:
  - A pixel is accepted on any cycle with in_valid=1. Gaps between pixels are allowed.
  - Accepted pixels advance col; at IMG_W-1, col wraps to 0 and row increments; at the last pixel of row IMG_H-1, row wraps to 0.
  - in_sof=1 with in_valid forces this pixel to (0,0) regardless of counter state; the partial previous frame is abandoned and produces no further outputs.
- Windowing:
  - Accepting pixel (R,C) with R≥2 and C≥2 completes the window for centre (R-1, C-1).
  - Only interior pixels produce output: exactly (IMG_W-2)*(IMG_H-2) results per frame, in raster order.
  - Line buffers hold rows R-1 and R-2; the window shifts only on accepted pixels.
- Arithmetic:
  - gx = P(r, c+1) − P(r, c−1) and gy = P(r+1, c) − P(r−1, c), both PIX_W+1-bit signed.
  - mag_sq = gx² + gy², exact. Maximum is 2*(2^PIX_W−1)² = 130050 for PIX_W=8, which fits 18 bits.
- Orientation:
  - Normalise: if gy<0, or gy=0 and gx<0, negate both so the angle lies in [0,180°).
  - For k=1..8, θk=20k°. Test tk = (gy*Ck − gx*Sk ≥ 0), where Ck=round(1024·cos θk) and Sk=round(1024·sin θk) are signed Q1.10 constants; products are full-width signed.
  - bin = number of true tk. Bin n therefore covers [20n, 20n+20)°.
  - If gx=gy=0, bin=0.
- Latency: out_valid asserts exactly 3 clk after the posedge that accepted the completing pixel.
  - S1: difference registers.
  - S2: squares, normalisation, products.
  - S3: sum and compare into the outputs.
  - Holds for back-to-back or gapped input.
- Output timing: out_valid is a 1-cycle pulse per result. out_mag_sq and out_bin hold their last value when out_valid=0.
- No backpressure: the consumer must accept every pulse.

Test Plan:
- IMG_W=8, IMG_H=6, constant pixel 77, continuous in_valid → exactly 24 out_valid pulses, all mag_sq=0, bin=0; first pulse 3 clk after accepting pixel (2,2).
- Horizontal ramp P=10c → every result gx=20, gy=0, mag_sq=400, bin=0.
- Vertical ramp P=10r → mag_sq=400, bin=4.
- Diagonal P=10(r+c) → mag_sq=800, bin=2.
- Reversed ramp P=200−10c → gx=−20, normalised to angle 0: mag_sq=400, bin=0.
- Step image, cols 0..3 = 0 and cols 4..7 = 255:
  - centres c=3 and c=4 give mag_sq=65025, bin=0; other centres give 0.
  - Repeat with random 0–3 cycle in_valid gaps → identical result sequence, same 3-cycle latency per result.
- Send 20 pixels of a frame, then in_sof with a new frame; separately, apply rst_n=0 for 2 cycles mid-frame then a fresh frame:
  - no stale outputs after the in_sof pixel or the reset;
  - the new frame yields exactly 24 correct results.

Source files
------------

// File: rtl/grad_mag_bin.sv
// Streaming HOG gradient stage: central-difference gradient per interior pixel,
// squared magnitude plus a 9-bin unsigned orientation index, fixed 3-cycle latency.
module grad_mag_bin #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int PIX_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic                 in_sof,
    input  logic [PIX_W-1:0]     in_pixel,
    output logic                 out_valid,
    output logic [2*PIX_W+1:0]   out_mag_sq,
    output logic [3:0]           out_bin
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int DW = PIX_W + 1;
    localparam int SW = 2 * DW;
    localparam int PW = DW + 12;

    // Q1.10 cos/sin of 20k degrees, k = 1..8
    localparam logic signed [11:0] COS_Q10 [8] = '{
        12'sd962, 12'sd784, 12'sd512, 12'sd178,
        -12'sd178, -12'sd512, -12'sd784, -12'sd962
    };
    localparam logic signed [11:0] SIN_Q10 [8] = '{
        12'sd350, 12'sd658, 12'sd887, 12'sd1008,
        12'sd1008, 12'sd887, 12'sd658, 12'sd350
    };

    logic [CW-1:0]          r_col, w_posCol, w_nextCol;
    logic [RW-1:0]          r_row, w_posRow, w_nextRow;
    logic                   w_lastCol, w_complete, w_flush;
    logic [PIX_W-1:0]       r_lb1 [IMG_W];
    logic [PIX_W-1:0]       r_lb2 [IMG_W];
    logic [PIX_W-1:0]       r_mid0, r_mid1, r_mid2, r_top0, r_top1, r_bot0, r_bot1;
    logic                   r_winValid, r_s1Valid, r_s2Valid;
    logic signed [DW-1:0]   r_gx, r_gy, w_nx, w_ny;
    logic signed [SW-1:0]   w_gxExt, w_gyExt, r_sqx, r_sqy;
    logic signed [PW-1:0]   w_nxExt, w_nyExt;
    logic signed [PW-1:0]   r_pc [8];
    logic signed [PW-1:0]   r_ps [8];
    logic                   r_zero;
    logic [3:0]             w_binCount;

    // An in_sof pixel is always (0,0) and abandons anything still in flight
    always_comb begin
        w_flush    = in_valid & in_sof;
        w_posCol   = in_sof ? '0 : r_col;
        w_posRow   = in_sof ? '0 : r_row;
        w_lastCol  = (w_posCol == CW'(IMG_W - 1));
        w_nextCol  = w_lastCol ? '0 : w_posCol + 1'b1;
        w_nextRow  = w_posRow;
        if (w_lastCol) begin
            w_nextRow = (w_posRow == RW'(IMG_H - 1)) ? '0 : w_posRow + 1'b1;
        end
        w_complete = in_valid && (w_posRow >= RW'(2)) && (w_posCol >= CW'(2));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (in_valid) begin
            r_col <= w_nextCol;
            r_row <= w_nextRow;
        end
    end

    // After accepting (R,C): mid = row R-1 cols C..C-2, top/bot = rows R-2/R at col C-1
    always_ff @(posedge clk) begin
        if (in_valid) begin
            r_lb2[w_posCol] <= r_lb1[w_posCol];
            r_lb1[w_posCol] <= in_pixel;
            r_mid0 <= r_lb1[w_posCol];
            r_mid1 <= r_mid0;
            r_mid2 <= r_mid1;
            r_top0 <= r_lb2[w_posCol];
            r_top1 <= r_top0;
            r_bot0 <= in_pixel;
            r_bot1 <= r_bot0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_winValid <= 1'b0;
            r_s1Valid  <= 1'b0;
            r_s2Valid  <= 1'b0;
        end else begin
            r_winValid <= w_complete;
            r_s1Valid  <= r_winValid & ~w_flush;
            r_s2Valid  <= r_s1Valid & ~w_flush;
        end
    end

    always_ff @(posedge clk) begin
        if (r_winValid) begin
            r_gx <= $signed({1'b0, r_mid0}) - $signed({1'b0, r_mid2});
            r_gy <= $signed({1'b0, r_bot1}) - $signed({1'b0, r_top1});
        end
    end

    // Fold the gradient into the upper half-plane so the angle lies in [0,180)
    always_comb begin
        w_nx = r_gx;
        w_ny = r_gy;
        if (r_gy < 0 || (r_gy == 0 && r_gx < 0)) begin
            w_nx = -r_gx;
            w_ny = -r_gy;
        end
        w_gxExt = SW'(r_gx);
        w_gyExt = SW'(r_gy);
        w_nxExt = PW'(w_nx);
        w_nyExt = PW'(w_ny);
    end

    always_ff @(posedge clk) begin
        if (r_s1Valid) begin
            r_sqx  <= w_gxExt * w_gxExt;
            r_sqy  <= w_gyExt * w_gyExt;
            r_zero <= (r_gx == 0) && (r_gy == 0);
            for (int k = 0; k < 8; k++) begin
                r_pc[k] <= w_nyExt * PW'(COS_Q10[k]);
                r_ps[k] <= w_nxExt * PW'(SIN_Q10[k]);
            end
        end
    end

    always_comb begin
        w_binCount = 4'd0;
        for (int k = 0; k < 8; k++) begin
            if (r_pc[k] >= r_ps[k]) begin
                w_binCount = w_binCount + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_mag_sq <= '0;
            out_bin    <= 4'd0;
        end else begin
            out_valid <= r_s2Valid & ~w_flush;
            if (r_s2Valid && !w_flush) begin
                out_mag_sq <= $unsigned(r_sqx) + $unsigned(r_sqy);
                out_bin    <= r_zero ? 4'd0 : w_binCount;
            end
        end
    end

endmodule

// File: tb/tb_grad_mag_bin.sv
// Directed bench for grad_mag_bin on an 8x6 image: hand-computed magnitude/bin per
// pattern, result count per frame, and exact 3-cycle latency per result.
module tb_grad_mag_bin;

    localparam int IMG_W = 8;
    localparam int IMG_H = 6;
    localparam int PIX_W = 8;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_sof;
    logic [PIX_W-1:0]     in_pixel;
    logic                 out_valid;
    logic [2*PIX_W+1:0]   out_mag_sq;
    logic [3:0]           out_bin;

    typedef struct {
        int magSq;
        int bin;
        int dueEdge;
    } expT;

    expT expQ[$];
    int  edgeCount   = 0;
    int  checks      = 0;
    int  errors      = 0;
    int  resultCount = 0;
    int  startCount;

    always #5 clk = ~clk;

    grad_mag_bin #(.IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .in_pixel   (in_pixel),
        .out_valid  (out_valid),
        .out_mag_sq (out_mag_sq),
        .out_bin    (out_bin)
    );

    always @(posedge clk) edgeCount <= edgeCount + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Every pulse must match the oldest outstanding expectation, on its due edge
    always @(negedge clk) begin
        expT e;
        if (rst_n === 1'b1 && out_valid !== 1'b0) begin
            resultCount++;
            if (expQ.size() == 0) begin
                checkOutput("spurious", 32'd1, 32'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput("magSq", 32'(out_mag_sq), e.magSq);
                checkOutput("bin", 32'(out_bin), e.bin);
                checkOutput("latency", edgeCount, e.dueEdge);
            end
        end
    end

    function automatic logic [PIX_W-1:0] pixVal(input int pat, input int r, input int c);
        int v;
        case (pat)
            0:       v = 77;
            1:       v = 10 * c;
            2:       v = 10 * r;
            3:       v = 10 * (r + c);
            4:       v = 200 - 10 * c;
            default: v = (c >= 4) ? 255 : 0;
        endcase
        return PIX_W'(v);
    endfunction

    function automatic int expMag(input int pat, input int centreCol);
        case (pat)
            0:       return 0;
            1, 2, 4: return 400;
            3:       return 800;
            default: return (centreCol == 3 || centreCol == 4) ? 65025 : 0;
        endcase
    endfunction

    function automatic int expBin(input int pat);
        case (pat)
            2:       return 4;
            3:       return 2;
            default: return 0;
        endcase
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_sof   = 1'b0;
        end
    endtask

    // Result is visible at the negedge after the third edge following acceptance
    task automatic applyStimulus(input logic [PIX_W-1:0] pix, input logic sof,
                                 input bit pushExp, input int eMag, input int eBin);
        expT e;
        @(negedge clk);
        in_valid = 1'b1;
        in_sof   = sof;
        in_pixel = pix;
        if (pushExp) begin
            e.magSq   = eMag;
            e.bin     = eBin;
            e.dueEdge = edgeCount + 4;
            expQ.push_back(e);
        end
    endtask

    task automatic sendFrame(input int pat, input int maxGap, input bit sof, input int nPix);
        int r;
        int c;
        for (int i = 0; i < nPix; i++) begin
            r = i / IMG_W;
            c = i % IMG_W;
            if (maxGap > 0) idle(int'($urandom_range(0, maxGap)));
            applyStimulus(pixVal(pat, r, c), sof && (i == 0), (r >= 2) && (c >= 2),
                          expMag(pat, c - 1), expBin(pat));
        end
    endtask

    task automatic checkFrame(input int fromCount, input string tag);
        idle(8);
        checkOutput({tag, "Count"}, resultCount - fromCount, (IMG_W - 2) * (IMG_H - 2));
        checkOutput({tag, "Drained"}, expQ.size(), 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_pixel = '0;
        idle(3);
        checkOutput("resetValid", 32'(out_valid), 0);
        checkOutput("resetMag", 32'(out_mag_sq), 0);
        checkOutput("resetBin", 32'(out_bin), 0);
        rst_n = 1'b1;

        for (int pat = 0; pat <= 5; pat++) begin
            startCount = resultCount;
            sendFrame(pat, 0, 1'b0, IMG_W * IMG_H);
            checkFrame(startCount, $sformatf("pat%0d", pat));
            if (pat == 3) begin
                checkOutput("holdValid", 32'(out_valid), 0);
                checkOutput("holdMag", 32'(out_mag_sq), 800);
                checkOutput("holdBin", 32'(out_bin), 2);
            end
        end

        startCount = resultCount;
        sendFrame(5, 3, 1'b0, IMG_W * IMG_H);
        checkFrame(startCount, "stepGapped");

        sendFrame(2, 0, 1'b0, 20);
        idle(6);
        startCount = resultCount;
        sendFrame(1, 0, 1'b1, IMG_W * IMG_H);
        checkFrame(startCount, "sofRestart");

        sendFrame(3, 0, 1'b0, 20);
        idle(6);
        rst_n = 1'b0;
        idle(2);
        checkOutput("midResetValid", 32'(out_valid), 0);
        checkOutput("midResetMag", 32'(out_mag_sq), 0);
        rst_n = 1'b1;
        startCount = resultCount;
        sendFrame(4, 0, 1'b0, IMG_W * IMG_H);
        checkFrame(startCount, "afterReset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
